instr_issue: RTL and testbench
==============================

Name: instr_issue

Overview:
- Instruction source for the 3-stage pipelined datapath. Drives the datapath's 32-bit instruction input, one word per cycle.
- Buffers a program loaded over a valid/ready port in a FIFO.
- The datapath has no forwarding, so this block detects read-after-write hazards against recently issued instructions. It inserts NOP bubbles (32'h0) until the producer's register-file write is visible.

Parameters:
- DEPTH, 16, FIFO entries (power of 2).
- ADDR_W, 4, log2(DEPTH).
- HAZ_DEPTH, 2, number of previously issued slots checked for hazards (2 matches 3-stage datapath with registered write-back).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load_instr valid.
- load_ready  out  1  FIFO can accept (= !full).
- load_instr  in  32  instruction word to enqueue.
- run  in  1  issue enable.
- Instrout  out  32  registered instruction to datapath Instrin.
- issue_valid  out  1  Instrout holds a real (popped) instruction this cycle.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- stall_count  out  16  hazard bubbles inserted, saturating.
- issued_count  out  16  instructions issued, saturating.

Behaviour:
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
  - Word 32'h0 = NOP: reads nothing, writes nothing.
  - Nonzero word with opcode[5]=0 = R-type: reads rs, rt; writes rd.
  - opcode[5]=1 = I-type: reads rs; writes rt.
- Reset (synchronous, at clock edge):
  - FIFO pointers and count cleared; empty=1, full=0.
  - Instrout=0, issue_valid=0, counters=0.
  - All scoreboard entries invalid.
  - Reset mid-operation discards queued and in-flight tracking immediately.
- FIFO:
  - Enqueue when load_valid && load_ready.
  - load_ready=!full. No enqueue while full, even if a pop occurs the same cycle.
  - Simultaneous enqueue and pop when neither empty nor full: count unchanged.
  - Pointers wrap modulo DEPTH.
  - A word enqueued into an empty FIFO is issuable no earlier than the next cycle (no fall-through).
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {valid, dest[4:0]}. Entry0 describes the current Instrout; entry1 the previous word.
  - Shifts every cycle. New entry0 = {writes && issuing, dest} of the word loaded into Instrout.
  - Bubbles shift in valid=0.
- Hazard (combinational on FIFO head): asserted if any valid entry's dest equals a register the head reads.
- Issue, each edge when not in reset:
  - run && !empty && !hazard: Instrout<=head, pop, issue_valid<=1, issued_count++.
  - run && !empty && hazard: Instrout<=0, issue_valid<=0, stall_count++.
  - Otherwise (run=0 or empty): Instrout<=0, issue_valid<=0, no counter change.
- Timing: a dependent instruction reaches Instrout no sooner than 3 cycles after its producer. Back-to-back dependency costs exactly 2 bubbles; a gap of 1 independent instruction costs 1 bubble.
- run=0 pauses issue; the scoreboard keeps draining, so hazards clear during the pause.
- Counters saturate at 16'hFFFF.

Optional Feature:
- R0_FILTER_EN:
  - Defined: a destination of register 0 never sets a valid scoreboard entry, and reads of r0 never hazard.
  - Undefined: r0 is treated like any other register. NOP (32'h0) never creates an entry in either case.

Test Plan:
- Reset then load 0x04221800 (add r3,r1,r2) and 0x04A63800 (add r7,r5,r6), run=1 -> Instrout shows 0x04221800 then 0x04A63800 on consecutive cycles; issued_count=2, stall_count=0.
- Load 0x04221800 then 0x84640005 (addi r4,r3,5) -> sequence 0x04221800, 0, 0, 0x84640005; stall_count=2.
- Load 0x04221800, 0x04A63800, 0x84640005 -> sequence 0x04221800, 0x04A63800, 0, 0x84640005; stall_count=1.
- Enqueue 16 words with run=0 -> full=1, load_ready=0, and a 17th word is refused. Raise run -> all 16 issued in order, one per cycle; pointers wrap; empty=1 afterwards.
- Dependent pair loaded, run=0 for 3 cycles after the producer issues, then run=1 -> consumer issues on the first run cycle with no stall.
- Assert reset with 5 words queued and hazard pending -> next cycle Instrout=0, empty=1, counters=0. With R0_FILTER_EN defined, 0x04220000 (writes r0) followed by 0x84000001 (reads r0) issues back-to-back.

Source files
------------

// File: rtl/instr_issue.sv
// instr_issue: program FIFO plus hazard-aware issue stage feeding the
// 3-stage datapath (no forwarding). RAW hazards against the last HAZ_DEPTH
// issued words are resolved by issuing NOP bubbles (32'h0).
// Optional feature macro: R0_FILTER_EN (r0 neither produces nor consumes hazards).
module instr_issue #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int HAZ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_instr,
    input  logic        run,
    output logic [31:0] Instrout,
    output logic        issue_valid,
    output logic        empty,
    output logic        full,
    output logic [15:0] stall_count,
    output logic [15:0] issued_count
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic [HAZ_DEPTH-1:0] sb_valid;
    logic [4:0]           sb_dest [HAZ_DEPTH];

    logic [31:0] head;
    logic        head_nop;
    logic        head_rtype;
    logic [4:0]  head_rs;
    logic [4:0]  head_rt;
    logic [4:0]  head_dest;
    logic        reads_rs;
    logic        reads_rt;
    logic        head_writes;
    logic        hazard;
    logic        push;
    logic        issue;
    logic        stall;

    assign full       = (count == (ADDR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign load_ready = !full;
    assign head       = mem[rd_ptr];

    assign push  = load_valid && !full;
    assign issue = run && !empty && !hazard;
    assign stall = run && !empty && hazard;

    // Decode the FIFO head and compare its sources against in-flight destinations
    always_comb begin
        head_nop    = (head == '0);
        head_rtype  = !head[31];
        head_rs     = head[25:21];
        head_rt     = head[20:16];
        head_dest   = head_rtype ? head[15:11] : head[20:16];
        reads_rs    = !head_nop;
        reads_rt    = !head_nop && head_rtype;
        head_writes = !head_nop;
`ifdef R0_FILTER_EN
        reads_rs    = reads_rs && (head_rs != 5'd0);
        reads_rt    = reads_rt && (head_rt != 5'd0);
        head_writes = head_writes && (head_dest != 5'd0);
`endif
        hazard = 1'b0;
        for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_valid[i] && ((reads_rs && sb_dest[i] == head_rs) ||
                                (reads_rt && sb_dest[i] == head_rt)))
                hazard = 1'b1;
        end
    end

    // FIFO storage write (no reset needed; occupancy is tracked by count)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= load_instr;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scoreboard shifts every cycle; bubbles and pauses shift in invalid entries
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid <= '0;
            for (int unsigned i = 0; i < HAZ_DEPTH; i++)
                sb_dest[i] <= '0;
        end else begin
            for (int unsigned i = HAZ_DEPTH - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
            sb_valid[0] <= head_writes && issue;
            sb_dest[0]  <= head_dest;
        end
    end

    // Issue register and saturating statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            Instrout     <= '0;
            issue_valid  <= 1'b0;
            stall_count  <= '0;
            issued_count <= '0;
        end else begin
            Instrout    <= issue ? head : '0;
            issue_valid <= issue;
            if (issue && issued_count != '1)
                issued_count <= issued_count + 16'd1;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Directed self-checking bench for instr_issue.
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_instr;
    logic        run;
    logic [31:0] Instrout;
    logic        issue_valid;
    logic        empty;
    logic        full;
    logic [15:0] stall_count;
    logic [15:0] issued_count;

    int checks = 0;
    int errors = 0;

    instr_issue #(.DEPTH(16), .ADDR_W(4), .HAZ_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_instr   (load_instr),
        .run          (run),
        .Instrout     (Instrout),
        .issue_valid  (issue_valid),
        .empty        (empty),
        .full         (full),
        .stall_count  (stall_count),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; load_valid = 1'b0; load_instr = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        load_valid = 1'b1;
        load_instr = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] w);
        tick();
        check(tag, Instrout, w);
        check({tag, "_v"}, {31'd0, issue_valid}, (w != 32'h0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        do_reset();
        check("rst_instr", Instrout, 32'h0);
        check("rst_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        check("rst_stall", {16'd0, stall_count}, 32'd0);
        check("rst_issued", {16'd0, issued_count}, 32'd0);

        // Independent pair issues back-to-back
        push(32'h04221800);
        push(32'h04A63800);
        run = 1'b1;
        expect_issue("ind_0", 32'h04221800);
        expect_issue("ind_1", 32'h04A63800);
        expect_issue("ind_2", 32'h0);
        check("ind_empty", {31'd0, empty}, 32'd1);
        check("ind_issued", {16'd0, issued_count}, 32'd2);
        check("ind_stall", {16'd0, stall_count}, 32'd0);

        // Back-to-back dependency: two bubbles
        do_reset();
        push(32'h04221800);
        push(32'h84640005);
        run = 1'b1;
        expect_issue("dep_0", 32'h04221800);
        expect_issue("dep_1", 32'h0);
        expect_issue("dep_2", 32'h0);
        expect_issue("dep_3", 32'h84640005);
        check("dep_stall", {16'd0, stall_count}, 32'd2);
        check("dep_issued", {16'd0, issued_count}, 32'd2);

        // One independent instruction between producer and consumer: one bubble
        do_reset();
        push(32'h04221800);
        push(32'h04A63800);
        push(32'h84640005);
        run = 1'b1;
        expect_issue("gap_0", 32'h04221800);
        expect_issue("gap_1", 32'h04A63800);
        expect_issue("gap_2", 32'h0);
        expect_issue("gap_3", 32'h84640005);
        check("gap_stall", {16'd0, stall_count}, 32'd1);

        // Fill the FIFO with run low, refuse a 17th word, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = 32'h8000_0000 | ((i + 1) << 16) | i;
            push(w);
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_ready", {31'd0, load_ready}, 32'd0);
        check("fill_empty", {31'd0, empty}, 32'd0);
        push(32'hDEAD_BEEF);
        check("fill_still_full", {31'd0, full}, 32'd1);
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 32'h8000_0000 | ((i + 1) << 16) | i;
            expect_issue($sformatf("drain_%0d", i), w);
        end
        expect_issue("drain_end", 32'h0);
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_issued", {16'd0, issued_count}, 32'd16);
        check("drain_stall", {16'd0, stall_count}, 32'd0);
        // Pointers have wrapped; a word pushed into an empty FIFO issues one cycle later
        load_valid = 1'b1;
        load_instr = 32'h04221800;
        tick();
        load_valid = 1'b0;
        check("nofall_instr", Instrout, 32'h0);
        check("nofall_empty", {31'd0, empty}, 32'd0);
        expect_issue("wrap_issue", 32'h04221800);

        // Pause after the producer: hazard drains during the pause
        do_reset();
        push(32'h04221800);
        push(32'h84640005);
        run = 1'b1;
        expect_issue("pause_prod", 32'h04221800);
        run = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_issue($sformatf("pause_%0d", i), 32'h0);
        run = 1'b1;
        expect_issue("pause_cons", 32'h84640005);
        check("pause_stall", {16'd0, stall_count}, 32'd0);

        // Reset mid-operation with words queued and a hazard pending
        do_reset();
        push(32'h04221800);
        push(32'h84640005);
        push(32'h04A63800);
        push(32'h04A63800);
        push(32'h04A63800);
        run = 1'b1;
        expect_issue("mid_prod", 32'h04221800);
        expect_issue("mid_bub", 32'h0);
        check("mid_stall", {16'd0, stall_count}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        check("mid_rst_instr", Instrout, 32'h0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_stall", {16'd0, stall_count}, 32'd0);
        check("mid_rst_issued", {16'd0, issued_count}, 32'd0);

        // r0 producer followed by r0 consumer
        do_reset();
        push(32'h04220000);
        push(32'h84000001);
        run = 1'b1;
        expect_issue("r0_prod", 32'h04220000);
`ifdef R0_FILTER_EN
        expect_issue("r0_cons", 32'h84000001);
        check("r0_stall", {16'd0, stall_count}, 32'd0);
`else
        expect_issue("r0_bub0", 32'h0);
        expect_issue("r0_bub1", 32'h0);
        expect_issue("r0_cons", 32'h84000001);
        check("r0_stall", {16'd0, stall_count}, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
